// File: rtl/cpu_posted_write_fifo.sv
// cpu_posted_write_fifo: posted-write buffer between the CPU port and the system bus.
// Writes drain in order; reads forward from the queue or wait for it to empty.
module cpu_posted_write_fifo #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit FORWARD = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  output logic              o_bus_rw,
  output logic              o_bus_request,
  input  logic              i_bus_ready,
  output logic [ADDR_W-1:0] o_bus_address,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_rw,
  input  logic              i_request,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] o_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_full,
  output logic              o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     idx;
  logic [CW-1:0]     count;
  logic              full;
  logic              cpu_go;
  logic              push;
  logic              pop;
  logic              hit;
  logic              fwd;
  logic [DATA_W-1:0] fwd_data;

  assign full    = count == CW'(DEPTH);
  assign cpu_go  = i_request && !o_ready && state != READ;
  assign push    = cpu_go && i_rw && !full;
  assign pop     = state == WRITE && i_bus_ready;
  assign fwd     = cpu_go && !i_rw && hit;
  assign o_full  = full;
  assign o_empty = count == '0 && state == IDLE;

  // Walk oldest to newest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count && addr_q[idx] == i_address) begin
        hit      = FORWARD;
        fwd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      addr_q[wr_ptr] <= i_address;
      data_q[wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      o_ready       <= 1'b0;
      o_rdata       <= '0;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (o_ready && !i_request) o_ready <= 1'b0;
      else if (push || fwd) o_ready <= 1'b1;
      if (fwd) o_rdata <= fwd_data;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state         <= WRITE;
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b1;
            o_bus_address <= addr_q[rd_ptr];
            o_bus_wdata   <= data_q[rd_ptr];
          end else if (cpu_go && !i_rw) begin
            state         <= READ;
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b0;
            o_bus_address <= i_address;
          end
        end
        WRITE: begin
          if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            state         <= IDLE;
          end
        end
        READ: begin
          // An issued read always finishes; completion is dropped if the CPU left.
          if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            o_rdata       <= i_bus_rdata;
            o_ready       <= i_request;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_posted_write_fifo.sv
// tb_cpu_posted_write_fifo: directed scoreboard bench for the posted-write buffer.
// Stimulus queues expected bus beats and read data; monitors pop and compare.
module tb_cpu_posted_write_fifo;
  typedef struct packed {
    logic        rw;
    logic [31:0] a;
    logic [31:0] d;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_rw, bus_req, cpu_ready, full, empty;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_addr, bus_wdata, cpu_rdata;
  logic [31:0] rd_val = 32'h0;
  logic        cpu_rw = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;

  int   tests = 0;
  int   fails = 0;
  bus_t exp_bus[$];
  logic [31:0] exp_rd[$];
  int   bus_lat = 1;
  bit   bus_hold = 1'b0;
  int   wait_cnt = 0;
  int   bus_txn = 0;
  logic prev_ready = 1'b0;

  always #5 clk = ~clk;

  cpu_posted_write_fifo #(
    .DEPTH(4), .ADDR_W(32), .DATA_W(32), .FORWARD(1'b1)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .o_bus_rw     (bus_rw),
    .o_bus_request(bus_req),
    .i_bus_ready  (bus_ready),
    .o_bus_address(bus_addr),
    .i_bus_rdata  (rd_val),
    .o_bus_wdata  (bus_wdata),
    .i_rw         (cpu_rw),
    .i_request    (cpu_req),
    .o_ready      (cpu_ready),
    .i_address    (cpu_addr),
    .o_rdata      (cpu_rdata),
    .i_wdata      (cpu_wdata),
    .o_full       (full),
    .o_empty      (empty)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: ready after bus_lat idle negedges, one cycle wide.
  always @(negedge clk) begin : bus_model
    bus_t e;
    if (bus_ready) bus_ready = 1'b0;
    else if (bus_req && !bus_hold) begin
      if (wait_cnt >= bus_lat) begin
        bus_ready = 1'b1;
        wait_cnt = 0;
        bus_txn++;
        if (exp_bus.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bus_unexpected: got rw=%b addr=%h, expected none",
                   bus_rw, bus_addr);
        end else begin
          e = exp_bus.pop_front();
          check("bus_rw", 32'(bus_rw), 32'(e.rw));
          check("bus_addr", bus_addr, e.a);
          if (e.rw) check("bus_wdata", bus_wdata, e.d);
        end
      end else wait_cnt++;
    end
  end

  always @(negedge clk) begin : cpu_monitor
    if (cpu_ready && !prev_ready && !cpu_rw) begin
      if (exp_rd.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL cpu_unexpected: got rdata %h, expected none", cpu_rdata);
      end else check("cpu_rdata", cpu_rdata, exp_rd.pop_front());
    end
    prev_ready = cpu_ready;
  end

  task automatic cpu_op(input logic rw, input logic [31:0] addr,
                        input logic [31:0] data, output int lat);
    cpu_rw = rw;
    cpu_addr = addr;
    cpu_wdata = data;
    cpu_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cpu_ready && lat < 300);
    if (!cpu_ready) begin
      tests++;
      fails++;
      $display("FAIL cpu_timeout: got no o_ready, expected o_ready at %h", addr);
    end
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    output int lat);
    exp_bus.push_back('{1'b1, addr, data});
    cpu_op(1'b1, addr, data, lat);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d,
                    input bit fwd, output int lat);
    if (!fwd) exp_bus.push_back('{1'b0, addr, 32'h0});
    exp_rd.push_back(exp_d);
    cpu_op(1'b0, addr, 32'h0, lat);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((!empty || exp_bus.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(empty), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int l, l5, t0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: three writes drain in order
    bus_lat = 1;
    for (int i = 0; i < 3; i++) begin
      wr(32'hA0 + 32'(i * 4), 32'hD0 + 32'(i), l);
      check("t1_wr_lat", 32'(l), 32'd1);
    end
    wait_drain("t1_empty");

    // 2: fill to DEPTH with the bus stalled; fifth write waits for a pop
    bus_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr(32'h2000 + 32'(i * 4), 32'hB0 + 32'(i), l);
      check("t2_wr_lat", 32'(l), 32'd1);
    end
    check("t2_full", 32'(full), 32'd1);
    fork
      wr(32'h2010, 32'hB4, l5);
      begin
        repeat (5) @(posedge clk);
        bus_hold = 1'b0;
      end
    join
    check("t2_wr5_stalled", 32'(l5 > 5), 32'd1);
    check("t2_full_again", 32'(full), 32'd1);
    wait_drain("t2_empty");

    // 3: forward newest of two writes to the same address
    bus_hold = 1'b1;
    t0 = bus_txn;
    wr(32'h100, 32'hCAFE, l);
    wr(32'h100, 32'hBEEF, l);
    rd(32'h100, 32'hBEEF, 1'b1, l);
    check("t3_fwd_lat", 32'(l), 32'd1);
    bus_hold = 1'b0;
    wait_drain("t3_empty");
    check("t3_bus_txns", 32'(bus_txn - t0), 32'd2);

    // 4: read miss waits behind two queued writes
    bus_lat = 3;
    rd_val = 32'h1234_5678;
    wr(32'h300, 32'h11, l);
    wr(32'h304, 32'h22, l);
    rd(32'h200, 32'h1234_5678, 1'b0, l);
    check("t4_miss_slow", 32'(l > 1), 32'd1);
    wait_drain("t4_empty");

    // 5: asynchronous reset during a bus write with three queued
    bus_lat = 1;
    bus_hold = 1'b1;
    for (int i = 0; i < 3; i++) wr(32'h500 + 32'(i * 4), 32'h50 + 32'(i), l);
    check("t5_req_before", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_req_async", 32'(bus_req), 32'd0);
    check("t5_empty_async", 32'(empty), 32'd1);
    check("t5_full_async", 32'(full), 32'd0);
    exp_bus.delete();
    t0 = bus_txn;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus_hold = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_bus", 32'(bus_txn - t0), 32'd0);
    check("t5_empty_after", 32'(empty), 32'd1);

    // 6: fill, then push against pops so pointers wrap; order must hold
    bus_hold = 1'b1;
    for (int i = 0; i < 4; i++) wr(32'h600 + 32'(i * 4), 32'h60 + 32'(i), l);
    fork
      begin
        wr(32'h610, 32'h64, l);
        wr(32'h614, 32'h65, l);
        wr(32'h618, 32'h66, l);
      end
      begin
        repeat (3) @(posedge clk);
        bus_hold = 1'b0;
      end
    join
    wait_drain("t6_empty");
    rd_val = 32'hA5A5_0001;
    rd(32'h600, 32'hA5A5_0001, 1'b0, l);
    wait_drain("t6_stale_empty");

    check("end_bus_queue", 32'(exp_bus.size()), 32'd0);
    check("end_rd_queue", 32'(exp_rd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
